// File: rtl/haze_pkg.sv
`default_nettype none
// ============================================================================
// Module : haze_pkg
// Brief  : Shared constants and helpers for the haze radiance-recovery stage
// Rev    : 1.0  initial release
// ============================================================================
package haze_pkg;

  localparam int HAZE_T_MIN_DEF = 26;
  localparam int HAZE_NUM_W_DEF = 16;

  function automatic int haze_num_w(input int dw, input int tw);
    return dw + tw;
  endfunction

  function automatic int haze_lat(input int dw, input int tw);
    return dw + tw + 2;
  endfunction

  // Clamp a signed value into the unsigned range [0, 2^dw-1].
  function automatic logic signed [63:0] sat_u(input logic signed [63:0] value, input int dw);
    logic signed [63:0] top;
    top = (64'sd1 <<< dw) - 64'sd1;
    if (value < 64'sd0) return 64'sd0;
    if (value > top) return top;
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/haze_recover_pipe_div.sv
`default_nettype none
// ============================================================================
// Module : haze_div_pipe
// Brief  : Fully pipelined unsigned restoring divider, one quotient bit/stage
// Rev    : 1.0  initial release
// ============================================================================
module haze_div_pipe #(
  parameter int NUM_W = 16,
  parameter int T_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_W-1:0] num,
  input  logic [T_W-1:0]   den,
  output logic [NUM_W-1:0] quo
);

  // nq holds the unconsumed numerator bits on top; quotient bits shift in below.
  logic [T_W-1:0]   rem_w [NUM_W];
  logic [T_W-1:0]   den_w [NUM_W];
  logic [NUM_W-1:0] nq_w  [NUM_W+1];

  assign rem_w[0] = '0;
  assign den_w[0] = den;
  assign nq_w[0]  = num;

  for (genvar i = 0; i < NUM_W; i++) begin : g_stage
    logic [T_W:0]     trial;
    logic             ge;
    logic [NUM_W-1:0] nq_d, nq_q;

    always_comb begin
      trial = {rem_w[i], nq_w[i][NUM_W-1]};
      ge    = (trial >= {1'b0, den_w[i]});
      nq_d  = {nq_w[i][NUM_W-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) nq_q <= '0;
      else     nq_q <= nq_d;
    end

    assign nq_w[i+1] = nq_q;

    // The final stage needs neither a remainder nor the divisor downstream.
    if (i < NUM_W-1) begin : g_carry
      logic [T_W-1:0] rem_d, rem_q, den_q;

      always_comb begin
        rem_d = ge ? (trial[T_W-1:0] - den_w[i]) : trial[T_W-1:0];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rem_q <= '0;
          den_q <= '0;
        end else begin
          rem_q <= rem_d;
          den_q <= den_w[i];
        end
      end

      assign rem_w[i+1] = rem_q;
      assign den_w[i+1] = den_q;
    end
  end

  assign quo = nq_w[NUM_W];

endmodule
`default_nettype wire

// File: rtl/haze_recover_pipe.sv
`default_nettype none
// ============================================================================
// Module : haze_recover_pipe
// Brief  : Scene radiance J = A + (I-A)*2^T_W/max(t,T_MIN), with saturation stat
// Rev    : 1.0  initial release
// ============================================================================
module haze_recover_pipe
  import haze_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CH    = 3,
  parameter int T_W   = 8,
  parameter int T_MIN = HAZE_T_MIN_DEF,
  parameter int CNT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pre_frame_vsync,
  input  logic               pre_frame_href,
  input  logic               pre_frame_clken,
  input  logic [CH*DW-1:0]   pre_img,
  input  logic [T_W-1:0]     pre_tx_img,
  input  logic [CH*DW-1:0]   pre_A,
  input  logic               cfg_bypass,
  output logic               post_frame_vsync,
  output logic               post_frame_href,
  output logic               post_frame_clken,
  output logic [CH*DW-1:0]   post_img,
  output logic [CNT_W-1:0]   sat_count,
  output logic               sat_count_valid
);

  localparam int NUM_W = haze_num_w(DW, T_W);
  localparam int LAT   = haze_lat(DW, T_W);
  localparam int RW    = NUM_W + 2;
  localparam int SB_W  = 1 + CH + 2*CH*DW;
  localparam logic [T_W-1:0]   T_MIN_V = T_W'(T_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Sideband layout: {bypass, sign[CH], A, I}
  logic [T_W-1:0]   tdiv_d, tdiv_q;
  logic [NUM_W-1:0] num_d [CH];
  logic [NUM_W-1:0] num_q [CH];
  logic [NUM_W-1:0] quo_w [CH];
  logic [SB_W-1:0]  sb_d;
  logic [SB_W-1:0]  sb_q [NUM_W+1];
  logic [2:0]       ctl_d;
  logic [2:0]       ctl_q [LAT];
  logic [DW-1:0]    s1_i, s1_a, s1_mag;
  logic [CH-1:0]    s1_s;

  always_comb begin
    tdiv_d = (pre_tx_img < T_MIN_V) ? T_MIN_V : pre_tx_img;
    s1_i   = '0;
    s1_a   = '0;
    s1_mag = '0;
    s1_s   = '0;
    for (int c = 0; c < CH; c++) begin
      s1_i     = pre_img[c*DW +: DW];
      s1_a     = pre_A[c*DW +: DW];
      s1_s[c]  = (s1_i < s1_a);
      s1_mag   = s1_s[c] ? (s1_a - s1_i) : (s1_i - s1_a);
      num_d[c] = {s1_mag, {T_W{1'b0}}};
    end
    sb_d  = {cfg_bypass, s1_s, pre_A, pre_img};
    ctl_d = {pre_frame_vsync, pre_frame_href, pre_frame_clken};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdiv_q <= '0;
      for (int c = 0; c < CH; c++) num_q[c] <= '0;
      for (int k = 0; k <= NUM_W; k++) sb_q[k] <= '0;
      for (int k = 0; k < LAT; k++) ctl_q[k] <= '0;
    end else begin
      tdiv_q <= tdiv_d;
      for (int c = 0; c < CH; c++) num_q[c] <= num_d[c];
      sb_q[0] <= sb_d;
      for (int k = 1; k <= NUM_W; k++) sb_q[k] <= sb_q[k-1];
      ctl_q[0] <= ctl_d;
      for (int k = 1; k < LAT; k++) ctl_q[k] <= ctl_q[k-1];
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_div
    haze_div_pipe #(.NUM_W(NUM_W), .T_W(T_W)) u_div (
      .clk (clk),
      .rst (rst),
      .num (num_q[c]),
      .den (tdiv_q),
      .quo (quo_w[c])
    );
  end

  logic [SB_W-1:0]        fin_sb;
  logic [DW-1:0]          fin_a;
  logic signed [RW-1:0]   fin_ax, fin_qx, fin_r;
  logic signed [63:0]     fin_rx, fin_sv;
  logic [CH*DW-1:0]       img_mix, post_img_d, post_img_q;
  logic                   clip_any, byp, satf_d, satf_q;

  always_comb begin
    fin_sb   = sb_q[NUM_W];
    fin_a    = '0;
    fin_ax   = '0;
    fin_qx   = '0;
    fin_r    = '0;
    fin_rx   = '0;
    fin_sv   = '0;
    img_mix  = '0;
    clip_any = 1'b0;
    for (int c = 0; c < CH; c++) begin
      fin_a   = fin_sb[CH*DW + c*DW +: DW];
      fin_ax  = {{(RW-DW){1'b0}}, fin_a};
      fin_qx  = {2'b00, quo_w[c]};
      fin_r   = fin_sb[2*CH*DW + c] ? (fin_ax - fin_qx) : (fin_ax + fin_qx);
      fin_rx  = {{(64-RW){fin_r[RW-1]}}, fin_r};
      fin_sv  = sat_u(fin_rx, DW);
      clip_any = clip_any | (fin_sv != fin_rx);
      img_mix[c*DW +: DW] = fin_sv[DW-1:0];
    end
    byp        = fin_sb[SB_W-1];
    post_img_d = byp ? fin_sb[CH*DW-1:0] : img_mix;
    satf_d     = !byp && clip_any;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_img_q <= '0;
      satf_q     <= 1'b0;
    end else begin
      post_img_q <= post_img_d;
      satf_q     <= satf_d;
    end
  end

  assign post_frame_vsync = ctl_q[LAT-1][2];
  assign post_frame_href  = ctl_q[LAT-1][1];
  assign post_frame_clken = ctl_q[LAT-1][0];
  assign post_img         = post_img_q;

  // Frame statistic lives in output timing; a saturated pixel on the vsync edge opens the new frame.
  logic             vs_prev_q, vs_rise, sat_pix;
  logic [CNT_W-1:0] acc_d, acc_q, sat_count_d, sat_count_q;
  logic             sat_valid_d, sat_valid_q;

  always_comb begin
    vs_rise     = post_frame_vsync & ~vs_prev_q;
    sat_pix     = post_frame_clken & satf_q;
    acc_d       = acc_q;
    sat_count_d = sat_count_q;
    sat_valid_d = vs_rise;
    if (vs_rise) begin
      acc_d       = {{(CNT_W-1){1'b0}}, sat_pix};
      sat_count_d = acc_q;
    end else if (sat_pix && (acc_q != CNT_MAX)) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q   <= 1'b0;
      acc_q       <= '0;
      sat_count_q <= '0;
      sat_valid_q <= 1'b0;
    end else begin
      vs_prev_q   <= post_frame_vsync;
      acc_q       <= acc_d;
      sat_count_q <= sat_count_d;
      sat_valid_q <= sat_valid_d;
    end
  end

  assign sat_count       = sat_count_q;
  assign sat_count_valid = sat_valid_q;

endmodule
`default_nettype wire
